// File: rtl/output_port_scheduler.sv
// Round-robin, credit-gated scheduler that shares one router output link among
// the N/S/E/W input handlers and the cache read-return path (index 0..4).
module output_port_scheduler #(
  parameter int DEST_W  = 8,
  parameter int NET_W   = 4,
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            req,
  input  logic [5*DEST_W-1:0]   req_dest,
  input  logic [5*NET_W-1:0]    req_src,
  input  logic [4:0]            req_read,
  input  logic [4:0]            req_write,
  input  logic [5*DATA_W-1:0]   req_data,
  output logic [4:0]            grant,
  input  logic                  credit_return,
  output logic                  out_valid,
  output logic [DEST_W-1:0]     out_dest,
  output logic [NET_W-1:0]      out_src,
  output logic                  out_read,
  output logic                  out_write,
  output logic [DATA_W-1:0]     out_data,
  output logic [3:0]            credit_cnt,
  output logic                  credit_err
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        credit_q, credit_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [NET_W-1:0]  src_q, src_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic       any_grant;
  logic [2:0] sel;
  logic [3:0] cand;

  // Search starts at rr_ptr and wraps 4 -> 0; no grant while in reset or out of credit.
  always_comb begin
    grant     = '0;
    sel       = '0;
    any_grant = 1'b0;
    cand      = '0;
    if (!reset && credit_q != 4'd0) begin
      for (int off = 0; off < 5; off++) begin
        cand = {1'b0, rr_ptr_q} + 4'(off);
        if (cand >= 4'd5) cand = cand - 4'd5;
        if (!any_grant && req[cand[2:0]]) begin
          any_grant        = 1'b1;
          sel              = cand[2:0];
          grant[cand[2:0]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    credit_d = credit_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    read_d   = 1'b0;
    write_d  = 1'b0;
    dest_d   = dest_q;
    src_d    = src_q;
    data_d   = data_q;

    if (any_grant) begin
      rr_ptr_d = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
      valid_d  = 1'b1;
      read_d   = req_read[sel];
      write_d  = req_write[sel];
      dest_d   = req_dest[sel*DEST_W +: DEST_W];
      src_d    = req_src[sel*NET_W +: NET_W];
      data_d   = req_data[sel*DATA_W +: DATA_W];
    end

    // A return at full count is a downstream protocol error; the count saturates.
    if (credit_return && credit_q == CRED_MAX) err_d = 1'b1;

    if (any_grant && !credit_return) begin
      credit_d = credit_q - 4'd1;
    end else if (!any_grant && credit_return && credit_q != CRED_MAX) begin
      credit_d = credit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      credit_q <= CRED_MAX;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      dest_q   <= '0;
      src_q    <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      read_q   <= read_d;
      write_q  <= write_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      data_q   <= data_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_read   = read_q;
  assign out_write  = write_q;
  assign out_dest   = dest_q;
  assign out_src    = src_q;
  assign out_data   = data_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: inputs change 1ns after a rising
// edge, all checks happen at the falling edge.
module tb_output_port_scheduler;

  logic         clk;
  logic         reset;
  logic [4:0]   req;
  logic [39:0]  req_dest;
  logic [19:0]  req_src;
  logic [4:0]   req_read;
  logic [4:0]   req_write;
  logic [159:0] req_data;
  logic [4:0]   grant;
  logic         credit_return;
  logic         out_valid;
  logic [7:0]   out_dest;
  logic [3:0]   out_src;
  logic         out_read;
  logic         out_write;
  logic [31:0]  out_data;
  logic [3:0]   credit_cnt;
  logic         credit_err;

  int n_assert = 0;
  int n_fail   = 0;

  output_port_scheduler #(.DEST_W(8), .NET_W(4), .DATA_W(32), .CREDITS(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .req_src(req_src),
    .req_read(req_read), .req_write(req_write), .req_data(req_data), .grant(grant),
    .credit_return(credit_return), .out_valid(out_valid), .out_dest(out_dest),
    .out_src(out_src), .out_read(out_read), .out_write(out_write),
    .out_data(out_data), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [4:0] exp_g3 [6];
  logic [4:0] exp_g4 [6];
  logic [3:0] exp_c4 [6];
  logic       exp_v4 [6];

  initial begin
    reset = 1'b1; req = '0; credit_return = 1'b0;
    req_read = '0; req_write = '0; req_src = '0; req_data = '0; req_dest = '0;
    for (int i = 0; i < 5; i++) begin
      req_dest[i*8 +: 8]  = 8'hA0 + 8'(i);
      req_src[i*4 +: 4]   = 4'(i + 1);
      req_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end
    tick(); tick();
    reset = 1'b0;

    // Reset then idle
    @(negedge clk);
    chk("rst_credit", 64'(credit_cnt), 64'd4);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_err", 64'(credit_err), 64'd0);
    chk("rst_dest", 64'(out_dest), 64'd0);
    tick();

    // Single North request
    req = 5'b00001;
    req_dest[7:0] = 8'h12; req_data[31:0] = 32'hDEADBEEF; req_read = 5'b00001;
    @(negedge clk);
    chk("n_grant", 64'(grant), 64'b00001);
    tick();
    req = '0;
    @(negedge clk);
    chk("n_valid", 64'(out_valid), 64'd1);
    chk("n_dest", 64'(out_dest), 64'h12);
    chk("n_data", 64'(out_data), 64'hDEADBEEF);
    chk("n_src", 64'(out_src), 64'd1);
    chk("n_read", 64'(out_read), 64'd1);
    chk("n_write", 64'(out_write), 64'd0);
    chk("n_credit", 64'(credit_cnt), 64'd3);
    chk("n_grant_idle", 64'(grant), 64'd0);
    tick();
    @(negedge clk);
    chk("n_valid_drop", 64'(out_valid), 64'd0);
    chk("n_dest_hold", 64'(out_dest), 64'h12);
    req_dest[7:0] = 8'hA0; req_data[31:0] = 32'h1000_0000; req_read = '0;
    do_reset();

    // All requesting, credit returned every cycle
    exp_g3 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    req = 5'b11111; credit_return = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", c), 64'(grant), 64'(exp_g3[c]));
      chk($sformatf("rr_credit%0d", c), 64'(credit_cnt), 64'd4);
      if (c > 0) chk($sformatf("rr_dest%0d", c), 64'(out_dest), 64'(8'hA0 + 8'(c - 1)));
      tick();
    end
    req = '0; credit_return = 1'b0;
    do_reset();

    // All requesting, no credit return: four grants then stall
    exp_g4 = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00000, 5'b00000};
    exp_c4 = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    exp_v4 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    req = 5'b11111;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) credit_return = 1'b1;
      @(negedge clk);
      chk($sformatf("st_grant%0d", c), 64'(grant), 64'(exp_g4[c]));
      chk($sformatf("st_credit%0d", c), 64'(credit_cnt), 64'(exp_c4[c]));
      chk($sformatf("st_valid%0d", c), 64'(out_valid), 64'(exp_v4[c]));
      tick();
    end
    credit_return = 1'b0;
    @(negedge clk);
    chk("st_cache_grant", 64'(grant), 64'b10000);
    chk("st_cache_credit", 64'(credit_cnt), 64'd1);
    tick();
    req = '0;
    @(negedge clk);
    chk("st_cache_valid", 64'(out_valid), 64'd1);
    chk("st_cache_dest", 64'(out_dest), 64'hA4);
    chk("st_cache_credit0", 64'(credit_cnt), 64'd0);
    tick();

    // Grant and return together at count 2, then overflow return
    credit_return = 1'b1;
    tick(); tick();
    req = 5'b00001;
    @(negedge clk);
    chk("sim_credit_pre", 64'(credit_cnt), 64'd2);
    chk("sim_grant", 64'(grant), 64'b00001);
    tick();
    req = '0;
    @(negedge clk);
    chk("sim_credit_post", 64'(credit_cnt), 64'd2);
    tick(); tick();
    @(negedge clk);
    chk("full_credit", 64'(credit_cnt), 64'd4);
    chk("full_err_clear", 64'(credit_err), 64'd0);
    tick();
    credit_return = 1'b0;
    @(negedge clk);
    chk("ovf_credit", 64'(credit_cnt), 64'd4);
    chk("ovf_err", 64'(credit_err), 64'd1);
    tick();
    @(negedge clk);
    chk("ovf_err_sticky", 64'(credit_err), 64'd1);
    do_reset();

    // Reset mid-stream with out_valid=1 and one credit left
    req = 5'b11111;
    tick(); tick(); tick();
    @(negedge clk);
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_credit", 64'(credit_cnt), 64'd1);
    chk("mid_grant", 64'(grant), 64'b01000);
    reset = 1'b1;
    #1;
    chk("mid_grant_rst", 64'(grant), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_valid_after", 64'(out_valid), 64'd0);
    chk("mid_credit_after", 64'(credit_cnt), 64'd4);
    chk("mid_dest_after", 64'(out_dest), 64'd0);
    chk("mid_err_after", 64'(credit_err), 64'd0);
    chk("mid_grant_n", 64'(grant), 64'b00001);
    tick();
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_scheduler.md
# output_port_scheduler

Round-robin scheduler with credit-based flow control for one router output port. It shares the outgoing link among five requesters: the North, South, East and West input port handlers, and the cache read-return path. Each cycle it grants at most one requester and registers the selected packet onto the link. It stalls whenever the downstream receiver has no buffer credit left. One instance sits at each output port, in place of fixed-priority select logic.

## Interface
Parameters:
- DEST_W, 8, destination field width (network address + cache bank address)
- NET_W, 4, requester network address width
- DATA_W, 32, data field width
- CREDITS, 4, downstream buffer depth; legal range 1..15

Ports:
- clk  in  1  all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  5  request vector, index 0=N, 1=S, 2=E, 3=W, 4=cache; held until granted
- req_dest  in  5*DEST_W  per-requester destination, slice i = bits [i*DEST_W +: DEST_W]
- req_src  in  5*NET_W  per-requester requester address
- req_read  in  5  per-requester read flag
- req_write  in  5  per-requester write flag
- req_data  in  5*DATA_W  per-requester data
- grant  out  5  one-hot or zero, combinational; grant[i]=1 means requester i is accepted this cycle
- credit_return  in  1  downstream freed one buffer slot this cycle
- out_valid  out  1  registered, packet present on link
- out_dest  out  DEST_W  registered
- out_src  out  NET_W  registered
- out_read  out  1  registered, equals out_valid & selected read flag
- out_write  out  1  registered, equals out_valid & selected write flag
- out_data  out  DATA_W  registered
- credit_cnt  out  4  current credit count
- credit_err  out  1  sticky, credit_return received while credit_cnt==CREDITS

## Operation
- Eligibility: the scheduler grants only when credit_cnt != 0. If credit_cnt == 0, grant = 0 regardless of req.
- Arbitration: search req starting at rr_ptr, wrapping 4→0. The first set bit is granted. Exactly one bit of grant is set when any req bit is set and a credit is available.
- Pointer: on a grant to index k, rr_ptr <= (k==4) ? 0 : k+1. rr_ptr is unchanged when there is no grant. rr_ptr is 3 bits and never exceeds 4.
- Fairness: a continuously requesting source is granted within 5 grant cycles.
- Output register: on a grant to k, the next edge loads out_* from slice k and sets out_valid=1. With no grant, out_valid<=0, out_read<=0, out_write<=0, and out_dest, out_src and out_data hold their last values.
- Credit counter:
  - Grant without credit_return: decrement.
  - credit_return without grant: increment.
  - Both in the same cycle: unchanged.
  - credit_return at credit_cnt==CREDITS: count stays at CREDITS and credit_err <= 1.
- The block never grants at credit_cnt==0, so the counter cannot underflow.
- A requester deasserts req, or presents its next packet, in the cycle after it sees grant. The scheduler does not buffer unaccepted packets.

## Timing
- Reset (synchronous) sets: out_valid=0, out_read=0, out_write=0, out_dest=0, out_src=0, out_data=0, rr_ptr=0, credit_cnt=CREDITS, credit_err=0. grant is forced to 0 while reset=1.
- Reset asserted mid-stream drops any packet granted in that cycle. Credits restore to CREDITS immediately.
- Latency: grant in cycle t, packet valid on out_* in cycle t+1.
- Throughput: one packet per cycle while credits remain.
- credit_return in cycle t makes the credit usable for a grant in cycle t+1. It is not usable in the same cycle.
- Zero-credit stall: grant stays 0 until the cycle after credit_return.

## Test plan
- Reset then idle: credit_cnt=4, out_valid=0, grant=0, credit_err=0.
- Single N request with dest=0x12, data=0xDEADBEEF: grant=00001 at t, out_valid=1 with out_dest=0x12 and out_data=0xDEADBEEF at t+1, credit_cnt=3.
- All 5 requesting continuously, credit_return every cycle: grants N,S,E,W,cache,N in order, credit_cnt stays 4.
- All 5 requesting, no credit_return: 4 grants (N,S,E,W), then grant=0 and out_valid=0 with credit_cnt=0. One credit_return produces the cache grant one cycle later.
- Simultaneous grant and credit_return at credit_cnt=2: count stays 2. An extra credit_return at credit_cnt=4 sets credit_err=1 and the count stays 4.
- Reset asserted while out_valid=1 and credit_cnt=1: the next cycle shows out_valid=0, credit_cnt=4, rr_ptr=0, so the next grant goes to N if requesting.
